// File: rtl/matrix_scan_bcm.sv
// matrix_scan_bcm: HUB75 panel scan controller. It uses binary-code modulation. The next bit-plane is shifted
//    while the previously latched plane is displayed.
// Latency: at least 4 clk_in per column (REQ, WAIT, SHIFT_LO, SHIFT_HI), plus HOLD and LATCH per plane.
// Backpressure: pixel_ready stalls the shift FSM in WAIT. The latch stalls in HOLD until the display period expires.
// Optional feature: define ROW_BLANK_EN for BLANK_TICKS of output_enable dead-time after each row change.
// Ports:
//    clk_in, reset                 - clock, synchronous active-high reset
//    pixel_ready                   - fetch block presents data for column_address/row_address
//    column_address, row_address   - pixel position being shifted
//    row_address_active            - row currently latched and displayed
//    brightness_mask               - one-hot bit-plane being shifted
//    clk_pixel_load                - one-cycle fetch request
//    clk_pixel, row_latch          - panel shift clock and latch strobe
//    output_enable                 - active-high display enable
//    frame_done                    - pulse on the latch of the last row's MSB plane
module matrix_scan_bcm #(
   parameter int COLUMNS       = 64,
   parameter int SCAN_ROWS     = 16,
   parameter int BIT_DEPTH     = 6,
   parameter int OE_BASE_TICKS = 4,
   parameter int BLANK_TICKS   = 2,
   localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
   localparam int RW = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 pixel_ready,
   output logic [CW-1:0]        column_address,
   output logic [RW-1:0]        row_address,
   output logic [RW-1:0]        row_address_active,
   output logic [BIT_DEPTH-1:0] brightness_mask,
   output logic                 clk_pixel_load,
   output logic                 clk_pixel,
   output logic                 row_latch,
   output logic                 output_enable,
   output logic                 frame_done
);

   localparam int PW     = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
   localparam int OE_MAX = OE_BASE_TICKS << (BIT_DEPTH - 1);
   localparam int OW     = $clog2(OE_MAX) + 1;

   // The state register names the state the outputs currently show.
   // The outputs for a state are registered on the edge that enters it.
   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_HOLD,
      S_LATCH
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_column;
   logic [RW-1:0]        r_row;
   logic [RW-1:0]        r_row_active;
   logic [BIT_DEPTH-1:0] r_mask;
   logic [PW-1:0]        r_plane;
   logic [OW-1:0]        r_oe_cnt;
   logic                 r_load;
   logic                 r_clk_pixel;
   logic                 r_row_latch;
   logic                 r_oe;
   logic                 r_frame_done;

   logic [PW-1:0]        w_mask_idx;
   logic [BIT_DEPTH-1:0] w_mask_rot;
   logic [OW-1:0]        w_oe_load;
   logic                 w_last_row;

`ifdef ROW_BLANK_EN
   localparam int BW = (BLANK_TICKS > 0) ? $clog2(BLANK_TICKS + 1) : 1;
   logic [BW-1:0]        r_blank_cnt;
`endif

   always_comb begin
      w_mask_idx = '0;
      for (int i = 0; i < BIT_DEPTH; i++) begin
         if (r_mask[i]) begin
            w_mask_idx = PW'(i);
         end
      end
   end

   assign w_mask_rot = (r_mask << 1) | (r_mask >> (BIT_DEPTH - 1));
   assign w_oe_load  = OW'(OE_BASE_TICKS) << r_plane;
   assign w_last_row = (r_row == RW'(SCAN_ROWS - 1));

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state      <= S_REQ;
         r_column     <= '0;
         r_row        <= '0;
         r_row_active <= '0;
         r_mask       <= BIT_DEPTH'(1);
         r_plane      <= '0;
         r_oe_cnt     <= '0;
         r_load       <= 1'b0;
         r_clk_pixel  <= 1'b0;
         r_row_latch  <= 1'b0;
         r_oe         <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef ROW_BLANK_EN
         r_blank_cnt  <= '0;
`endif
      end else begin
         r_row_latch  <= 1'b0;
         r_frame_done <= 1'b0;

         // Display timer. It starts on the edge that leaves LATCH, so OE rises at LATCH+1.
         if (r_state == S_LATCH) begin
            r_oe_cnt <= w_oe_load;
`ifdef ROW_BLANK_EN
            // A plane-0 latch is a row change. Hold OE low as dead-time against ghosting.
            if ((r_plane == '0) && (BLANK_TICKS > 0)) begin
               r_blank_cnt <= BW'(BLANK_TICKS);
               r_oe        <= 1'b0;
            end else begin
               r_oe        <= 1'b1;
            end
`else
            r_oe     <= 1'b1;
`endif
         end
`ifdef ROW_BLANK_EN
         else if (r_blank_cnt != '0) begin
            r_blank_cnt <= r_blank_cnt - BW'(1);
            r_oe        <= (r_blank_cnt == BW'(1));
         end
`endif
         else if (r_oe_cnt != '0) begin
            r_oe_cnt <= r_oe_cnt - OW'(1);
            r_oe     <= (r_oe_cnt != OW'(1));
         end

         case (r_state)
            S_REQ: begin
               // A load-low REQ occurs only straight out of reset. Issue the request now.
               if (!r_load) begin
                  r_load  <= 1'b1;
               end else begin
                  r_load  <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (pixel_ready) begin
                  r_state <= S_SHIFT_LO;
               end
            end
            S_SHIFT_LO: begin
               r_clk_pixel <= 1'b1;
               r_state     <= S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
               r_clk_pixel <= 1'b0;
               if (r_column != CW'(COLUMNS - 1)) begin
                  r_column <= r_column + CW'(1);
                  r_load   <= 1'b1;
                  r_state  <= S_REQ;
               end else begin
                  r_state  <= S_HOLD;
               end
            end
            S_HOLD: begin
               // With OE low in this cycle, at least one dark cycle precedes every latch.
               if ((r_oe_cnt == '0) && !r_oe) begin
                  r_state      <= S_LATCH;
                  r_row_latch  <= 1'b1;
                  r_row_active <= r_row;
                  r_plane      <= w_mask_idx;
                  r_column     <= '0;
                  r_mask       <= w_mask_rot;
                  r_frame_done <= w_last_row && r_mask[BIT_DEPTH-1];
                  if (r_mask[BIT_DEPTH-1]) begin
                     r_row <= w_last_row ? '0 : r_row + RW'(1);
                  end
               end
            end
            S_LATCH: begin
               r_load  <= 1'b1;
               r_state <= S_REQ;
            end
            default: begin
               r_state <= S_REQ;
            end
         endcase
      end
   end

   assign column_address     = r_column;
   assign row_address        = r_row;
   assign row_address_active = r_row_active;
   assign brightness_mask    = r_mask;
   assign clk_pixel_load     = r_load;
   assign clk_pixel          = r_clk_pixel;
   assign row_latch          = r_row_latch;
   assign output_enable      = r_oe;
   assign frame_done         = r_frame_done;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// tb_matrix_scan_bcm: directed bench for matrix_scan_bcm with 4 columns, 2 rows, 2 planes and an OE base of 2 ticks.
// Latency: a fetch responder answers each clk_pixel_load after a programmable or random delay.
// Backpressure: a scoreboard holds the expected latch order, and a per-cycle monitor checks it against the DUT.
module tb_matrix_scan_bcm;
   localparam int COLS = 4;
   localparam int ROWS = 2;
   localparam int BD   = 2;
   localparam int OEB  = 2;
   localparam int BLK  = 2;
`ifdef ROW_BLANK_EN
   localparam int BLANK_EXP = BLK;
`else
   localparam int BLANK_EXP = 0;
`endif

   logic          clk_in = 1'b0;
   logic          reset = 1'b1;
   logic          pixel_ready = 1'b0;
   logic [1:0]    column_address;
   logic [0:0]    row_address;
   logic [0:0]    row_address_active;
   logic [BD-1:0] brightness_mask;
   logic          clk_pixel_load;
   logic          clk_pixel;
   logic          row_latch;
   logic          output_enable;
   logic          frame_done;

   always #5 clk_in = ~clk_in;

   matrix_scan_bcm #(
      .COLUMNS(COLS), .SCAN_ROWS(ROWS), .BIT_DEPTH(BD),
      .OE_BASE_TICKS(OEB), .BLANK_TICKS(BLK)
   ) dut (
      .clk_in(clk_in), .reset(reset), .pixel_ready(pixel_ready),
      .column_address(column_address), .row_address(row_address),
      .row_address_active(row_address_active), .brightness_mask(brightness_mask),
      .clk_pixel_load(clk_pixel_load), .clk_pixel(clk_pixel), .row_latch(row_latch),
      .output_enable(output_enable), .frame_done(frame_done)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int row;
      int plane;
   } lat_t;
   lat_t sb_q[$];

   int  ready_delay = 0;
   bit  ready_rand  = 1'b0;
   int  n_frames    = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_frames(input int n);
      lat_t e;
      for (int f = 0; f < n; f++)
         for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < BD; p++) begin
               e.row = r;
               e.plane = p;
               sb_q.push_back(e);
            end
   endtask

   task automatic wait_frames(input int n, input int budget);
      int target;
      target = n_frames + n;
      for (int i = 0; i < budget; i++) begin
         if (n_frames >= target) break;
         @(posedge clk_in);
      end
      chk("frame_timeout", int'(n_frames >= target), 1);
   endtask

   // Fetch responder: pixel_ready is raised for one cycle, 1+delay cycles after the request.
   initial begin
      bit pend;
      int wait_left;
      pend = 1'b0;
      wait_left = 0;
      forever begin
         @(negedge clk_in);
         if (reset) begin
            pend = 1'b0;
         end else if (clk_pixel_load) begin
            pend = 1'b1;
            wait_left = ready_rand ? int'($urandom_range(0, 6)) : ready_delay;
         end
         @(posedge clk_in);
         #1;
         pixel_ready = 1'b0;
         if (pend) begin
            if (wait_left == 0) begin
               pixel_ready = 1'b1;
               pend = 1'b0;
            end else begin
               wait_left--;
            end
         end
      end
   end

   // Monitor: per-cycle invariants, OE window after each latch, and scoreboard pops at each row_latch.
   initial begin
      int edges, prev_clk, prev_oe, prev_load, prev_col;
      int win_k, win_blank, win_len;
      lat_t e;
      edges = 0; prev_clk = 0; prev_oe = 0; prev_load = 0; prev_col = 0;
      win_k = 0; win_blank = 0; win_len = 0;
      forever begin
         @(negedge clk_in);
         if (reset) begin
            sb_q.delete();
            edges = 0; prev_clk = 0; prev_oe = 0; prev_load = 0; prev_col = 0; win_k = 0;
         end else begin
            if (clk_pixel && prev_clk == 0) edges++;
            chk("latch_with_oe", int'(row_latch && output_enable), 0);
            chk("load_single", int'(clk_pixel_load && prev_load != 0), 0);
            if (int'(column_address) != prev_col)
               chk("col_step", int'((prev_clk == 1 && int'(column_address) == prev_col + 1) ||
                                    (row_latch && column_address == 2'd0)), 1);
            if (frame_done) chk("fd_outside_latch", int'(row_latch), 1);
            if (win_k > 0) begin
               chk("oe_window", int'(output_enable),
                   int'(win_k > win_blank && win_k <= win_blank + win_len));
               if (win_k == win_blank + win_len + 1) win_k = 0;
               else win_k++;
            end
            if (row_latch) begin
               chk("oe_low_before_latch", prev_oe, 0);
               chk("pixel_edges", edges, COLS);
               edges = 0;
               chk("col_zero_at_latch", int'(column_address), 0);
               chk("sb_has_entry", int'(sb_q.size() > 0), 1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  chk("row_active", int'(row_address_active), e.row);
                  chk("mask_next", int'(brightness_mask), (e.plane == BD - 1) ? 1 : (1 << (e.plane + 1)));
                  chk("row_next", int'(row_address), (e.plane == BD - 1) ? (e.row + 1) % ROWS : e.row);
                  chk("frame_done", int'(frame_done), int'(e.row == ROWS - 1 && e.plane == BD - 1));
                  win_k = 1;
                  win_len = OEB << e.plane;
                  win_blank = (e.plane == 0) ? BLANK_EXP : 0;
               end
               if (frame_done) n_frames++;
            end
            prev_clk = int'(clk_pixel);
            prev_oe = int'(output_enable);
            prev_load = int'(clk_pixel_load);
            prev_col = int'(column_address);
         end
      end
   end

   initial begin
      int cyc;
      bit found;
      reset = 1'b1;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      chk("rst_col", int'(column_address), 0);
      chk("rst_row", int'(row_address), 0);
      chk("rst_row_active", int'(row_address_active), 0);
      chk("rst_mask", int'(brightness_mask), 1);
      chk("rst_load", int'(clk_pixel_load), 0);
      chk("rst_clk_pixel", int'(clk_pixel), 0);
      chk("rst_latch", int'(row_latch), 0);
      chk("rst_oe", int'(output_enable), 0);
      chk("rst_frame_done", int'(frame_done), 0);

      // Phase 1: one-cycle fetch latency. The first latch comes 17 cycles after release.
      push_frames(2);
      @(posedge clk_in);
      #1 reset = 1'b0;
      cyc = 0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (row_latch) begin
            found = 1'b1;
            break;
         end
         cyc++;
      end
      chk("first_latch_cycle", found ? cyc : -1, 17);
      wait_frames(2, 2000);

      // Phase 2: slow fetch, 5 extra cycles per request.
      ready_delay = 5;
      push_frames(1);
      wait_frames(1, 2000);

      // Phase 3: random fetch delays over three frames.
      ready_rand = 1'b1;
      push_frames(3);
      wait_frames(3, 6000);

      // Phase 4: reset pulse while plane 1 is displayed, followed by a restart from (0,0).
      ready_rand = 1'b0;
      ready_delay = 0;
      push_frames(1);
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_in);
         if (row_latch && brightness_mask == 2'b01) begin
            found = 1'b1;
            break;
         end
      end
      chk("plane1_latch_seen", int'(found), 1);
      @(negedge clk_in);
      chk("oe_high_before_reset", int'(output_enable), 1);
      @(posedge clk_in);
      #1 reset = 1'b1;
      @(posedge clk_in);
      #1 reset = 1'b0;
      push_frames(1);
      @(negedge clk_in);
      chk("mid_rst_oe", int'(output_enable), 0);
      chk("mid_rst_col", int'(column_address), 0);
      chk("mid_rst_mask", int'(brightness_mask), 1);
      chk("mid_rst_row_active", int'(row_address_active), 0);
      wait_frames(1, 2000);
      chk("sb_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
